// File: rtl/clk_div_cfg_ctrl.sv
// rtl/clk_div_cfg_ctrl.sv - configuration sequencer for the programmable clock divider
// Validates period/high/phase requests and re-arms the divider through a timed reset pulse.
module clk_div_cfg_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEF_HIGH   = 1,
  parameter int unsigned DEF_LOW    = 1,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic [WIDTH-1:0] cfg_phase,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [7:0]       err_cnt,
  output logic             running,
  output logic [WIDTH-1:0] div_high_count,
  output logic [WIDTH-1:0] div_low_count,
  output logic [WIDTH-1:0] div_wait_count,
  output logic             div_rst
);

  typedef enum logic [1:0] {APPLY, RUN, CHECK} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(RST_CYCLES);

  state_t           state;
  logic [7:0]       hold;
  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_high;
  logic [WIDTH-1:0] sh_phase;
  logic             req_legal;

  // high < period and phase < period already imply period >= 1; period >= 2 is checked explicitly
  assign req_legal = (sh_period >= WIDTH'(2)) && (sh_high != '0) &&
                     (sh_high < sh_period) && (sh_phase < sh_period);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state          <= APPLY;
      hold           <= HOLD_INIT;
      sh_period      <= '0;
      sh_high        <= '0;
      sh_phase       <= '0;
      div_high_count <= WIDTH'(DEF_HIGH);
      div_low_count  <= WIDTH'(DEF_LOW);
      div_wait_count <= '0;
      div_rst        <= 1'b1;
      cfg_ready      <= 1'b0;
      cfg_done       <= 1'b0;
      cfg_err        <= 1'b0;
      err_cnt        <= '0;
      running        <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        APPLY: begin
          if (hold <= 8'd1) begin
            state     <= RUN;
            div_rst   <= 1'b0;
            running   <= 1'b1;
            cfg_ready <= 1'b1;
            cfg_done  <= 1'b1;
          end else begin
            hold <= hold - 8'd1;
          end
        end
        RUN: begin
          if (cfg_valid && cfg_ready) begin
            sh_period <= cfg_period;
            sh_high   <= cfg_high;
            sh_phase  <= cfg_phase;
            cfg_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (req_legal) begin
            // counts move only together with the rising div_rst edge
            div_high_count <= sh_high;
            div_low_count  <= sh_period - sh_high;
            div_wait_count <= sh_phase;
            div_rst        <= 1'b1;
            running        <= 1'b0;
            cfg_err        <= 1'b0;
            hold           <= HOLD_INIT;
            state          <= APPLY;
          end else begin
            cfg_err   <= 1'b1;
            cfg_ready <= 1'b1;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
            state <= RUN;
          end
        end
        default: begin
          state <= APPLY;
          hold  <= HOLD_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// tb/tb_clk_div_cfg_ctrl.sv - self-checking bench for clk_div_cfg_ctrl
module tb_clk_div_cfg_ctrl;

  localparam int RST = 2;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_period = '0;
  logic [31:0] cfg_high = '0;
  logic [31:0] cfg_phase = '0;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  err_cnt;
  logic        running;
  logic [31:0] div_high_count;
  logic [31:0] div_low_count;
  logic [31:0] div_wait_count;
  logic        div_rst;

  int tests = 0;
  int failed = 0;

  logic [31:0] m_high, m_low, m_wait;
  logic [7:0]  m_errcnt;

  typedef struct {
    logic [31:0] period;
    logic [31:0] high;
    logic [31:0] phase;
    bit          legal;
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] ew;
    logic [7:0]  ecnt;
  } vec_t;

  vec_t vecs[9];

  clk_div_cfg_ctrl #(.WIDTH(32), .DEF_HIGH(1), .DEF_LOW(1), .RST_CYCLES(RST)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_cnt(err_cnt), .running(running),
    .div_high_count(div_high_count), .div_low_count(div_low_count),
    .div_wait_count(div_wait_count), .div_rst(div_rst)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_high", div_high_count, 1);
    chk("rst_low", div_low_count, 1);
    chk("rst_wait", div_wait_count, 0);
    chk("rst_div_rst", div_rst, 1);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_running", running, 0);
  endtask

  // called at the negedge where rst_n has just been released
  task automatic powerup();
    chk("pu_div_rst0", div_rst, 1);
    chk("pu_running0", running, 0);
    repeat (RST - 1) begin
      @(negedge clk_i);
      chk("pu_div_rst_hold", div_rst, 1);
    end
    @(negedge clk_i);
    chk("pu_div_rst_low", div_rst, 0);
    chk("pu_running", running, 1);
    chk("pu_done", cfg_done, 1);
    chk("pu_ready", cfg_ready, 1);
    chk("pu_high", div_high_count, 1);
    chk("pu_low", div_low_count, 1);
    chk("pu_wait", div_wait_count, 0);
    @(negedge clk_i);
    chk("pu_done_pulse", cfg_done, 0);
  endtask

  task automatic do_req(input logic [31:0] p, input logic [31:0] h, input logic [31:0] ph,
                        input bit legal, input logic [31:0] eh, input logic [31:0] el,
                        input logic [31:0] ew, input logic [7:0] ecnt);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (cfg_ready !== 1'b1) begin
      chk("ready_timeout", cfg_ready, 1);
      return;
    end
    cfg_valid = 1'b1; cfg_period = p; cfg_high = h; cfg_phase = ph;
    @(negedge clk_i);
    cfg_valid = 1'b0;
    cfg_period = $urandom; cfg_high = $urandom; cfg_phase = $urandom;
    chk("check_ready", cfg_ready, 0);
    chk("check_running", running, 1);
    @(negedge clk_i);
    if (legal) begin
      chk("apply_div_rst", div_rst, 1);
      chk("apply_high", div_high_count, eh);
      chk("apply_low", div_low_count, el);
      chk("apply_wait", div_wait_count, ew);
      chk("apply_err", cfg_err, 0);
      chk("apply_running", running, 0);
      chk("apply_ready", cfg_ready, 0);
      repeat (RST - 1) begin
        @(negedge clk_i);
        chk("apply_hold", div_rst, 1);
      end
      @(negedge clk_i);
      chk("run_div_rst", div_rst, 0);
      chk("run_ready", cfg_ready, 1);
      chk("run_done", cfg_done, 1);
      chk("run_running", running, 1);
    end else begin
      chk("rej_div_rst", div_rst, 0);
      chk("rej_ready", cfg_ready, 1);
      chk("rej_err", cfg_err, 1);
      chk("rej_done", cfg_done, 0);
      chk("rej_high", div_high_count, eh);
      chk("rej_low", div_low_count, el);
      chk("rej_wait", div_wait_count, ew);
    end
    chk("err_cnt", err_cnt, ecnt);
  endtask

  // reference: legality and derived counts straight from the request rules
  task automatic model_req(input logic [31:0] p, input logic [31:0] h, input logic [31:0] ph,
                           output bit legal);
    legal = (p >= 2) && (h >= 1) && (h <= p - 1) && (ph <= p - 1);
    if (legal) begin
      m_high = h; m_low = p - h; m_wait = ph;
    end else if (m_errcnt < 8'd255) begin
      m_errcnt = m_errcnt + 8'd1;
    end
  endtask

  initial begin
    bit lg;
    int dones;
    logic [31:0] p, h, ph;

    vecs[0] = '{10, 3, 4, 1, 3, 7, 4, 0};
    vecs[1] = '{ 5, 5, 0, 0, 3, 7, 4, 1};
    vecs[2] = '{ 1, 1, 0, 0, 3, 7, 4, 2};
    vecs[3] = '{ 8, 0, 0, 0, 3, 7, 4, 3};
    vecs[4] = '{ 8, 2, 8, 0, 3, 7, 4, 4};
    vecs[5] = '{ 8, 2, 7, 1, 2, 6, 7, 4};
    vecs[6] = '{ 2, 1, 1, 1, 1, 1, 1, 4};
    vecs[7] = '{ 2, 1, 2, 0, 1, 1, 1, 5};
    vecs[8] = '{ 7, 6, 0, 1, 6, 1, 0, 5};

    repeat (3) @(negedge clk_i);
    check_reset_vals();
    rst_n = 1'b1;
    powerup();

    foreach (vecs[i])
      do_req(vecs[i].period, vecs[i].high, vecs[i].phase, vecs[i].legal,
             vecs[i].eh, vecs[i].el, vecs[i].ew, vecs[i].ecnt);

    m_high = 6; m_low = 1; m_wait = 0; m_errcnt = 5;

    // two queued requests with cfg_valid held high throughout the first apply
    while (cfg_ready !== 1'b1) @(negedge clk_i);
    cfg_valid = 1'b1; cfg_period = 12; cfg_high = 5; cfg_phase = 2;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_i);
      if (c == 1) begin cfg_period = 9; cfg_high = 4; cfg_phase = 8; end
      if (c == 5) cfg_valid = 1'b0;
      if (cfg_done === 1'b1) dones++;
      if (c == 2) begin
        chk("b2b_first_high", div_high_count, 5);
        chk("b2b_first_low", div_low_count, 7);
        chk("b2b_first_rst", div_rst, 1);
      end
      if (c == 4) chk("b2b_ready_run", cfg_ready, 1);
      if (c == 5) chk("b2b_second_accept", cfg_ready, 0);
      if (c == 6) begin
        chk("b2b_second_high", div_high_count, 4);
        chk("b2b_second_low", div_low_count, 5);
        chk("b2b_second_wait", div_wait_count, 8);
        chk("b2b_second_rst", div_rst, 1);
      end
      if (c == 10) chk("b2b_idle_ready", cfg_ready, 1);
    end
    chk("b2b_done_pulses", dones, 2);
    m_high = 4; m_low = 5; m_wait = 8;

    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 12);
      h = $urandom_range(0, 13);
      ph = $urandom_range(0, 13);
      model_req(p, h, ph, lg);
      do_req(p, h, ph, lg, m_high, m_low, m_wait, m_errcnt);
    end

    for (int i = 0; i < 260; i++) begin
      model_req(1, 1, 0, lg);
      do_req(1, 1, 0, lg, m_high, m_low, m_wait, m_errcnt);
    end
    chk("err_cnt_saturated", err_cnt, 255);

    // reset dropped during APPLY
    while (cfg_ready !== 1'b1) @(negedge clk_i);
    cfg_valid = 1'b1; cfg_period = 6; cfg_high = 2; cfg_phase = 1;
    @(negedge clk_i);
    cfg_valid = 1'b0;
    @(negedge clk_i);
    chk("mid_apply_high", div_high_count, 2);
    chk("mid_apply_low", div_low_count, 4);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk_i);
    rst_n = 1'b1;
    powerup();
    m_high = 1; m_low = 1; m_wait = 0; m_errcnt = 0;
    do_req(10, 3, 4, 1, 3, 7, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
